// File: rtl/aes128_lane_gearbox_if.sv
// Line, lane, key and status bundle between the requestor, the gearbox and the cipher lanes.
`default_nettype none

interface aes128_lane_gearbox_if #(
  parameter int LINE_WIDTH  = 512,
  parameter int BLOCK_WIDTH = 128,
  parameter int NUM_LANES   = 4,
  parameter int TAG_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 8
);
  logic                             in_valid;
  logic                             in_ready;
  logic [LINE_WIDTH-1:0]            in_data;
  logic [TAG_WIDTH-1:0]             in_tag;
  logic [BLOCK_WIDTH-1:0]           key_in;
  logic                             key_valid_in;
  logic [BLOCK_WIDTH-1:0]           lane_key_out;
  logic                             lane_key_valid;
  logic [NUM_LANES*BLOCK_WIDTH-1:0] lane_data_out;
  logic                             lane_valid_out;
  logic [NUM_LANES*BLOCK_WIDTH-1:0] lane_data_in;
  logic                             lane_valid_in;
  logic                             out_valid;
  logic                             out_ready;
  logic [LINE_WIDTH-1:0]            out_data;
  logic [TAG_WIDTH-1:0]             out_tag;
  logic [$clog2(FIFO_DEPTH):0]      inflight_count;
  logic                             err_key_change;
  logic                             err_lane_orphan;

  modport slave (
    input  in_valid, in_data, in_tag, key_in, key_valid_in, lane_data_in, lane_valid_in, out_ready,
    output in_ready, lane_key_out, lane_key_valid, lane_data_out, lane_valid_out,
           out_valid, out_data, out_tag, inflight_count, err_key_change, err_lane_orphan
  );

  modport master (
    output in_valid, in_data, in_tag, key_in, key_valid_in, lane_data_in, lane_valid_in, out_ready,
    input  in_ready, lane_key_out, lane_key_valid, lane_data_out, lane_valid_out,
           out_valid, out_data, out_tag, inflight_count, err_key_change, err_lane_orphan
  );
endinterface

`default_nettype wire

// File: rtl/aes128_lane_gearbox.sv
// Splits cache lines into cipher blocks over NUM_LANES fixed-latency lanes and reassembles
// the lane results into tagged lines, in accept order.
`default_nettype none

module aes128_lane_gearbox #(
  parameter int LINE_WIDTH  = 512,
  parameter int BLOCK_WIDTH = 128,
  parameter int NUM_LANES   = 4,
  parameter int TAG_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  aes128_lane_gearbox_if.slave bus
);
  localparam int BLOCKS = LINE_WIDTH / BLOCK_WIDTH;
  localparam int BEATS  = BLOCKS / NUM_LANES;
  localparam int LANE_W = NUM_LANES * BLOCK_WIDTH;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int OW     = $clog2(FIFO_DEPTH * BEATS) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [BW-1:0]          beat, beat_nxt, col;
  logic [LINE_WIDTH-1:0]  line_q, asm_q, full_line;
  logic [CW-1:0]          inflight, tag_wp, tag_rp, out_wp, out_rp;
  logic [OW-1:0]          outstanding;
  logic                   in_ready, accept, at_last, lane_valid_out;
  logic                   pop, collect, last_collect, out_valid;
  logic [BLOCK_WIDTH-1:0] key_q;
  logic                   key_valid_q, err_key_q, err_orphan_q;
  logic [TAG_WIDTH-1:0]   tag_mem   [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]   otag_mem  [FIFO_DEPTH];
  logic [LINE_WIDTH-1:0]  oline_mem [FIFO_DEPTH];

  // in_ready depends on state and credit only, never on in_valid
  always_comb begin
    state_nxt      = state;
    beat_nxt       = beat;
    at_last        = (state == ISSUE) && (beat == LAST_BEAT);
    in_ready       = !reset && (inflight < DEPTH_C) && ((state == IDLE) || at_last);
    accept         = bus.in_valid && in_ready;
    lane_valid_out = (state == ISSUE);
    if (state == IDLE) begin
      if (accept) begin
        state_nxt = ISSUE;
        beat_nxt  = '0;
      end
    end else if (at_last) begin
      beat_nxt  = '0;
      state_nxt = accept ? ISSUE : IDLE;
    end else begin
      beat_nxt = beat + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  assign collect      = bus.lane_valid_in && (outstanding != '0);
  assign last_collect = collect && (col == LAST_BEAT);
  assign out_valid    = (out_wp != out_rp);
  assign pop          = out_valid && bus.out_ready;

  // Final beat goes straight from the lane bus into the pushed line
  always_comb begin
    full_line = asm_q;
    full_line[col*LANE_W +: LANE_W] = bus.lane_data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q       <= '0;
      col          <= '0;
      inflight     <= '0;
      outstanding  <= '0;
      tag_wp       <= '0;
      tag_rp       <= '0;
      out_wp       <= '0;
      out_rp       <= '0;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      err_key_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      if (accept) begin
        line_q <= bus.in_data;
        tag_wp <= tag_wp + 1'b1;
      end
      if (last_collect) begin
        tag_rp <= tag_rp + 1'b1;
        out_wp <= out_wp + 1'b1;
      end
      if (pop) out_rp <= out_rp + 1'b1;
      if (collect) col <= (col == LAST_BEAT) ? '0 : col + 1'b1;
      outstanding <= outstanding + OW'(lane_valid_out) - OW'(collect);
      if (accept && !pop)      inflight <= inflight + 1'b1;
      else if (!accept && pop) inflight <= inflight - 1'b1;
      key_q       <= bus.key_in;
      key_valid_q <= bus.key_valid_in;
      if (bus.key_valid_in && (inflight != '0)) err_key_q <= 1'b1;
      if (bus.lane_valid_in && (outstanding == '0)) err_orphan_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and the beat counter define validity
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wp[AW-1:0]] <= bus.in_tag;
    if (collect) asm_q[col*LANE_W +: LANE_W] <= bus.lane_data_in;
    if (last_collect) begin
      oline_mem[out_wp[AW-1:0]] <= full_line;
      otag_mem[out_wp[AW-1:0]]  <= tag_mem[tag_rp[AW-1:0]];
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.lane_valid_out  = lane_valid_out;
  assign bus.lane_data_out   = line_q[beat*LANE_W +: LANE_W];
  assign bus.lane_key_out    = key_q;
  assign bus.lane_key_valid  = key_valid_q;
  assign bus.out_valid       = out_valid;
  assign bus.out_data        = out_valid ? oline_mem[out_rp[AW-1:0]] : '0;
  assign bus.out_tag         = out_valid ? otag_mem[out_rp[AW-1:0]] : '0;
  assign bus.inflight_count  = inflight;
  assign bus.err_key_change  = err_key_q;
  assign bus.err_lane_orphan = err_orphan_q;

endmodule

`default_nettype wire
